and16_unit: RTL and testbench

- Registered 16-bit bitwise AND unit for the integer execution path of the scoreboard datapath.
- Accepts operand pairs over a valid/ready input channel and returns s = a & b over a valid/ready output channel.
- Fixed 1-cycle latency; ready/valid decoupled by an internal 2-entry skid stage, so full throughput is possible with registered in_ready.

---
 rtl/and16_pkg.sv | 21 ++
 rtl/and16_skid.sv | 73 +++++++
 rtl/and16_unit.sv | 80 ++++++++
 tb/tb_and16_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/and16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : and16_pkg                                               |
// | Purpose  : Shared types and constants for the and16_unit datapath. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package and16_pkg;

  // Operand/result width used when the unit is built at its native size.
  localparam int DEFAULT_WIDTH = 16;

  // One AND result as it travels through the skid entry and output register.
  // The zero flag is carried with the data so it is never recomputed
  // downstream of the registers.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic                     zero;
  } and_result_t;

endpackage : and16_pkg
`default_nettype wire

// File: rtl/and16_skid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : and16_skid                                              |
// | Purpose  : Generic 2-entry valid/ready skid buffer (output register|
// |            plus one skid entry). Upstream ready comes straight     |
// |            from a flop, yet a full 1 item/cycle stream is kept.    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module and16_skid
  import and16_pkg::*;
#(
  parameter type T = and_result_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  T     r_out;
  T     r_skid;
  logic r_out_valid;
  logic r_skid_valid;
  logic r_in_ready;

  logic w_accept;
  logic w_out_free;

  assign w_accept   = i_valid && r_in_ready;
  // The output register may be (re)loaded when it is empty or is handing
  // its item to the consumer on this same edge.
  assign w_out_free = !r_out_valid || i_ready;

  // Output register refills from the skid entry first so order is kept;
  // the skid entry only fills when the output register is stuck.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // ready was low, so no accept can coincide with this refill
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_accept) begin
        r_out       <= i_data;
        r_out_valid <= 1'b1;
      end else begin
        // data is left in place; only the valid flag drops
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= i_data;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out;

endmodule : and16_skid
`default_nettype wire

// File: rtl/and16_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : and16_unit                                              |
// | Purpose  : Registered bitwise AND (s = a & b) with zero flag,      |
// |            valid/ready on both sides, 1-cycle latency.             |
// | Options  : AND16_UNIT_OP_COUNT_EN adds op_count[15:0], a wrapping  |
// |            count of completed output transfers.                    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module and16_unit
  import and16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero
`ifdef AND16_UNIT_OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  // Same layout as and_result_t, sized to this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
  } res_t;

  res_t w_res;
  res_t w_out;

  // Result and its zero flag are formed before the registers, so both
  // leave the unit from flops.
  always_comb begin
    w_res      = '0;
    w_res.data = a & b;
    w_res.zero = ~|(a & b);
  end

  and16_skid #(
    .T (res_t)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_res),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out)
  );

  assign s    = w_out.data;
  assign zero = w_out.zero;

`ifdef AND16_UNIT_OP_COUNT_EN
  logic [15:0] r_op_count;

  // Count every completed output handshake; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= 16'h0000;
    end else if (out_valid && out_ready) begin
      r_op_count <= r_op_count + 16'h0001;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule : and16_unit
`default_nettype wire

// File: tb/tb_and16_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_and16_unit                                           |
// | Purpose  : Self-checking bench for and16_unit: queue-based model   |
// |            compared every cycle plus directed literal checks.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_and16_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        zero;
`ifdef AND16_UNIT_OP_COUNT_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;

  and16_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .zero      (zero)
`ifdef AND16_UNIT_OP_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the unit holds at most two results in arrival order; the head is
  // what the consumer sees. It accepts whenever it holds fewer than two.
  logic [15:0] q[$];
  logic [15:0] m_last;
  int          m_cnt;
  bit          live = 0;

  always @(posedge clk) begin
    bit pop;
    bit push;
    if (rst) begin
      q.delete();
      m_last = 16'h0;
      m_cnt  = 0;
      live   = 1;
    end else if (live) begin
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && (q.size() < 2);
      if (pop) begin
        m_last = q.pop_front();
        m_cnt  = (m_cnt + 1) % 65536;
      end
      if (push) q.push_back(a & b);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [15:0] es;
    if (live) begin
      es = (q.size() > 0) ? q[0] : m_last;
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("m_s", {16'd0, s}, {16'd0, es});
      chk("m_zero", {31'd0, zero}, {31'd0, (q.size() > 0) ? (es == 16'h0) : (live && m_last == 16'h0 && m_cnt != 0)});
`ifdef AND16_UNIT_OP_COUNT_EN
      chk("m_op_count", {16'd0, op_count}, m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_s", {16'd0, s}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);

    send(16'h0008, 16'h0006);
    chk("p1_valid", {31'd0, out_valid}, 32'd1);
    chk("p1_s", {16'd0, s}, 32'h0000);
    chk("p1_zero", {31'd0, zero}, 32'd1);

    send(16'hFFFF, 16'h00F0);
    chk("p2_s", {16'd0, s}, 32'h00F0);
    chk("p2_zero", {31'd0, zero}, 32'd0);

    send(16'hAAAA, 16'h5555);
    chk("p3_s", {16'd0, s}, 32'h0000);
    chk("p3_zero", {31'd0, zero}, 32'd1);

    // back-to-back stream at full rate
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      in_valid = 1'b1;
      step();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    step();

    // stall: two accepted, third held off
    out_ready = 1'b0;
    send(16'hF0F0, 16'hFF00);
    chk("stall1_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h0F0F, 16'h00FF);
    chk("stall2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall2_s", {16'd0, s}, 32'hF000);
    a = 16'h1234; b = 16'h00FF; in_valid = 1'b1;
    step();
    chk("stall3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall3_s", {16'd0, s}, 32'hF000);
    chk("stall3_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("rel1_s", {16'd0, s}, 32'h000F);
    chk("rel1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("rel2_s", {16'd0, s}, 32'h0034);
    chk("rel2_zero", {31'd0, zero}, 32'd0);
    step();
    chk("rel3_valid", {31'd0, out_valid}, 32'd0);

    // reset while full
    out_ready = 1'b0;
    send(16'h1111, 16'h1010);
    send(16'h2222, 16'h0220);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_s", {16'd0, s}, 32'd0);
`ifdef AND16_UNIT_OP_COUNT_EN
    chk("rst2_op_count", {16'd0, op_count}, 32'd0);
`endif
    out_ready = 1'b1;
    send(16'h0C0C, 16'h0F00);
    chk("post_s", {16'd0, s}, 32'h0C00);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_and16_unit
`default_nettype wire
